// File: rtl/face_mask_overlay_if.sv
// Stream bundle for face_mask_overlay: mask bit input, pixel input, composited pixel output.
// A beat moves on any rising edge where valid && ready; while valid=1 and ready=0 the source holds its payload stable.
interface face_mask_overlay_if #(
  parameter int PIX_W = 32
);
  logic             mask_valid;
  logic             mask_bit;
  logic             mask_ready;
  logic             pix_in_valid;
  logic [PIX_W-1:0] pix_in_data;
  logic             pix_in_ready;
  logic             pix_out_valid;
  logic [PIX_W-1:0] pix_out_data;
  logic             pix_out_last;
  logic             pix_out_ready;

  modport master (
    output mask_valid, mask_bit, pix_in_valid, pix_in_data, pix_out_ready,
    input  mask_ready, pix_in_ready, pix_out_valid, pix_out_data, pix_out_last
  );

  modport slave (
    input  mask_valid, mask_bit, pix_in_valid, pix_in_data, pix_out_ready,
    output mask_ready, pix_in_ready, pix_out_valid, pix_out_data, pix_out_last
  );
endinterface

// File: rtl/face_mask_overlay.sv
// Buffers one tile's face mask, then replaces masked pixels of the same tile with OVERLAY_VAL.
// Optional macro FACE_STAT_EN enables the face_pix_count statistic (tied to 0 otherwise).
module face_mask_overlay #(
  parameter int PIX_W       = 32,
  parameter int ADDR_W      = 14,
  parameter int TILE_MAX    = 10000,
  parameter int OVERLAY_VAL = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       tile_side,
  face_mask_overlay_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   face_pix_count,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE, LOAD, OVERLAY, DONE_S} state_t;

  state_t state, state_next;

  logic [ADDR_W:0] n_reg;
  logic [ADDR_W:0] n_m1;
  logic [ADDR_W:0] mcnt;
  logic [ADDR_W:0] pcnt;
  logic            in_done;
  logic            out_valid;
  logic [PIX_W-1:0] out_data;
  logic            out_last;
  logic            mask_buf [TILE_MAX];

  // Product is formed at full 32 bits so oversized tiles are rejected before truncation.
  logic [31:0] n_full;
  logic        n_legal;
  assign n_full  = 32'(tile_side) * 32'(tile_side);
  assign n_legal = (n_full != 32'd0) && (n_full <= 32'(TILE_MAX));
  assign n_m1    = n_reg - 1'b1;

  logic mask_xfer, in_xfer, out_xfer, legal_start;
  assign bus.mask_ready    = (state == LOAD);
  assign bus.pix_in_ready  = (state == OVERLAY) && !in_done && (!out_valid || bus.pix_out_ready);
  assign bus.pix_out_valid = out_valid;
  assign bus.pix_out_data  = out_data;
  assign bus.pix_out_last  = out_last;
  assign mask_xfer   = bus.mask_valid && bus.mask_ready;
  assign in_xfer     = bus.pix_in_valid && bus.pix_in_ready;
  assign out_xfer    = out_valid && bus.pix_out_ready;
  assign legal_start = (state == IDLE) && start && n_legal;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE_S);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (legal_start) state_next = LOAD;
      LOAD:    if (mask_xfer && (mcnt == n_m1)) state_next = OVERLAY;
      OVERLAY: if (out_xfer && out_last) state_next = DONE_S;
      DONE_S:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Buffer is never reset: each tile writes every entry before it is read back.
  always_ff @(posedge clk) begin
    if (mask_xfer) mask_buf[mcnt[ADDR_W-1:0]] <= bus.mask_bit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_reg     <= '0;
      mcnt      <= '0;
      pcnt      <= '0;
      in_done   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        if (n_legal) begin
          n_reg   <= n_full[ADDR_W:0];
          mcnt    <= '0;
          pcnt    <= '0;
          in_done <= 1'b0;
          err     <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end
      if (mask_xfer) mcnt <= mcnt + 1'b1;
      if (in_xfer) begin
        pcnt      <= pcnt + 1'b1;
        out_valid <= 1'b1;
        out_data  <= mask_buf[pcnt[ADDR_W-1:0]] ? PIX_W'(OVERLAY_VAL) : bus.pix_in_data;
        out_last  <= (pcnt == n_m1);
        if (pcnt == n_m1) in_done <= 1'b1;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef FACE_STAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          face_pix_count <= '0;
    else if (legal_start)                face_pix_count <= '0;
    else if (mask_xfer && bus.mask_bit)  face_pix_count <= face_pix_count + 1'b1;
  end
`else
  assign face_pix_count = '0;
`endif

endmodule

// File: doc/face_mask_overlay.md
Name: face_mask_overlay

Overview:
- Consumer end of the per-core face-detection output.
- Accepts one core tile's face mask as a raster-order bit stream and buffers it.
- Then accepts the same tile's pixel stream and emits each pixel replaced by OVERLAY_VAL wherever the mask bit is 1, drawing the white box outlines.
- Sits between the detection cores and the image reassembly/writer stage; one instance per core tile stream.

Parameters:
- PIX_W, 32: pixel width in bits; matches core image word.
- ADDR_W, 14: tile pixel index width.
- TILE_MAX, 10000: maximum pixels per tile; mask buffer depth.
- OVERLAY_VAL, 255: value written where mask=1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a tile using tile_side.
- tile_side  in  16  tile edge length in pixels (3*unit_size); tile pixels N = tile_side*tile_side.
- mask_valid  in  1  mask bit valid.
- mask_bit  in  1  face mask bit, raster order.
- mask_ready  out  1  block accepts mask bit.
- pix_in_valid  in  1  input pixel valid.
- pix_in_data  in  PIX_W  input pixel.
- pix_in_ready  out  1  block accepts pixel.
- pix_out_valid  out  1  output pixel valid.
- pix_out_data  out  PIX_W  composited pixel.
- pix_out_last  out  1  marks the final (N-th) output pixel.
- pix_out_ready  in  1  downstream accepts pixel.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the tile completes.
- err  out  1  sticky; set on an illegal start; cleared by the next legal start or by reset.
- face_pix_count  out  ADDR_W+1  number of mask bits set (see Optional Feature).

Behaviour:
- Reset (reset=0): state IDLE. All outputs 0, all counters 0. Mask buffer contents are not cleared; every tile rewrites all entries before reading them. Reset mid-tile abandons the tile immediately; no done pulse is produced.
- Transfer rule: a transfer occurs on any cycle where valid&&ready. Upstream must hold data stable while valid=1 and ready=0.
- IDLE:
  - start with 1<=N<=TILE_MAX: latch N, clear counters, clear err, go to LOAD.
  - start with N==0 or N>TILE_MAX: set err, stay IDLE.
- LOAD:
  - mask_ready=1.
  - Each transfer writes buf[mcnt]=mask_bit and increments mcnt.
  - The transfer with mcnt==N-1 moves to OVERLAY next cycle.
- OVERLAY:
  - Output register is one stage; latency is 1 cycle from input transfer to pix_out_valid.
  - pix_in_ready = !pix_out_valid || pix_out_ready, giving full throughput of one pixel per cycle.
  - On an input transfer at index pcnt:
    - pix_out_data = buf[pcnt] ? OVERLAY_VAL : pix_in_data.
    - pix_out_last = (pcnt==N-1).
    - pcnt increments.
  - When pix_out_valid=1 and pix_out_ready=0, data and last hold stable.
  - After the input transfer with pcnt==N-1, pix_in_ready stays 0.
  - The state moves to DONE on the cycle the last output transfers.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 from the IDLE cycle onward.
- start while busy=1 is ignored; it does not set err.
- Stream timing:
  - mask_valid outside LOAD: ignored, mask_ready=0.
  - pix_in_valid outside OVERLAY: ignored, pix_in_ready=0.
- Mask and pixel streams are strictly sequential per tile; no overlap.
- Width rules:
  - N is computed as a 32-bit product and compared to TILE_MAX before truncation to ADDR_W+1.
  - Counters are ADDR_W+1 bits wide and never wrap within a legal tile.

Optional Feature:
- Macro FACE_STAT_EN.
- Defined:
  - face_pix_count clears on a legal start.
  - It increments on each mask transfer with mask_bit=1.
  - It holds after done until the next legal start.
- Undefined: face_pix_count is tied to 0 and no counter logic is synthesized. All other behaviour is identical.

Test Plan:
- Basic tile: tile_side=3, mask=010_000_001, pixels 10..18, ready always 1 -> outputs 10,255,12,13,14,15,16,17,255; last on 9th pixel; done one cycle after last; face_pix_count=2 with FACE_STAT_EN, 0 without.
- Backpressure: tile_side=2, mask all 1, pixels 1..4, pix_out_ready toggled 1,0,0,1... -> output stays 255 and stable while stalled; pix_in_ready=0 while stalled; exactly 4 outputs; last on 4th.
- Illegal start: tile_side=0 -> err=1, busy=0. Then tile_side=101 (N=10201>TILE_MAX) -> err stays 1. Then legal tile_side=2 -> err=0, busy=1.
- Start while busy: a second start mid-LOAD with a different tile_side -> ignored; the tile completes with the original N.
- Reset mid-OVERLAY: reset low after 3 of 9 pixels -> all outputs 0, state IDLE, no done. A new tile afterwards with mask all 0 passes pixels unchanged; stale buffer bits do not appear.
- Max tile: tile_side=100, mask alternating bits -> 10000 outputs; odd-indexed pixels = 255; last asserted only on index 9999; face_pix_count=5000 with FACE_STAT_EN.
